// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if
//  Receive-side handshake between the serial receiver FIFO and its consumer
//  (the teletype keyboard register).
//  Signals:
//   rx_read   consumer -> FIFO  pop request, edge-detected by the FIFO
//   rx_rdy    FIFO -> consumer  head entry valid
//   rx_data   FIFO -> consumer  head data byte
//   rx_err    FIFO -> consumer  framing error stored with the head entry
//   rx_count  FIFO -> consumer  number of entries held
//   rx_ovr    FIFO -> consumer  sticky overrun flag
//  Modports:
//   master  consumer side (drives rx_read)
//   slave   receiver/FIFO side (drives everything else)
interface uart_rx_fifo_if #(
   parameter int unsigned DEPTH_LOG2 = 2
) ();

   logic                  rx_read;
   logic                  rx_rdy;
   logic [7:0]            rx_data;
   logic                  rx_err;
   logic [DEPTH_LOG2:0]   rx_count;
   logic                  rx_ovr;

   modport master (
      output rx_read,
      input  rx_rdy,
      input  rx_data,
      input  rx_err,
      input  rx_count,
      input  rx_ovr
   );

   modport slave (
      input  rx_read,
      output rx_rdy,
      output rx_data,
      output rx_err,
      output rx_count,
      output rx_ovr
   );

endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
//  8N1 serial receiver feeding a small receive FIFO, so characters arriving
//  while the CPU is slow to read the keyboard register are queued.
//  tty input is sampled only on the shared 16x baud enable.
//  Parameters:
//   DEPTH_LOG2  FIFO depth = 2**DEPTH_LOG2 entries (1..4)
//   STOP_CHK    1: a low stop bit is flagged as a framing error
//  Ports:
//   clk      system clock
//   rst      synchronous, active-high reset
//   mclkx16  one-clk enable pulse at 16x baud
//   rx       asynchronous serial input, idle high, LSB first
//   bus      consumer handshake (slave side): rx_read in; rx_rdy, rx_data,
//            rx_err, rx_count, rx_ovr out
module uart_rx_fifo #(
   parameter int unsigned DEPTH_LOG2 = 2,
   parameter bit          STOP_CHK   = 1'b1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          mclkx16,
   input  logic          rx,
   uart_rx_fifo_if.slave bus
);

   localparam int unsigned             Depth    = 2 ** DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0]     CountMax = Depth[DEPTH_LOG2:0];
   localparam logic [DEPTH_LOG2:0]     CountOne = 1;
   localparam logic [DEPTH_LOG2-1:0]   PtrOne   = 1;

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StData,
      StStop,
      StWaitHi
   } state_e;

   // ---------------------------------------------------------------------
   // Input synchroniser (resets to the idle-high line level)
   // ---------------------------------------------------------------------
   logic rx_meta_q;
   logic rxs_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         rx_meta_q <= 1'b1;
         rxs_q     <= 1'b1;
      end else begin
         rx_meta_q <= rx;
         rxs_q     <= rx_meta_q;
      end
   end

   // ---------------------------------------------------------------------
   // Receive FSM; all sampling qualified by the 16x tick
   // ---------------------------------------------------------------------
   state_e      state_q;
   logic [3:0]  tick_q;
   logic [2:0]  bit_q;
   logic [7:0]  shreg_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         tick_q  <= 4'd0;
         bit_q   <= 3'd0;
         shreg_q <= 8'd0;
      end else if (mclkx16) begin
         case (state_q)
            StIdle: begin
               if (!rxs_q) begin
                  state_q <= StStart;
                  tick_q  <= 4'd0;
               end
            end
            StStart: begin
               // Mid start bit: a high line here was only a glitch.
               if (tick_q == 4'd7) begin
                  if (rxs_q) begin
                     state_q <= StIdle;
                  end else begin
                     state_q <= StData;
                     tick_q  <= 4'd0;
                     bit_q   <= 3'd0;
                  end
               end else begin
                  tick_q <= tick_q + 4'd1;
               end
            end
            StData: begin
               // Tick counter wraps at 16, so tick 15 is mid-bit every bit.
               tick_q <= tick_q + 4'd1;
               if (tick_q == 4'd15) begin
                  shreg_q <= {rxs_q, shreg_q[7:1]};
                  bit_q   <= bit_q + 3'd1;
                  if (bit_q == 3'd7) begin
                     state_q <= StStop;
                  end
               end
            end
            StStop: begin
               tick_q <= tick_q + 4'd1;
               if (tick_q == 4'd15) begin
                  state_q <= rxs_q ? StIdle : StWaitHi;
               end
            end
            StWaitHi: begin
               // Break/framing: no start detection until the line idles.
               if (rxs_q) begin
                  state_q <= StIdle;
               end
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

   // Push strobe coincides with the stop-bit sample.
   logic       push;
   logic [8:0] push_entry;

   assign push       = mclkx16 && (state_q == StStop) && (tick_q == 4'd15);
   assign push_entry = {STOP_CHK & ~rxs_q, shreg_q};

   // ---------------------------------------------------------------------
   // Receive FIFO
   // ---------------------------------------------------------------------
   logic [8:0]             mem_q [Depth];
   logic [DEPTH_LOG2-1:0]  wr_ptr_q, wr_ptr_d;
   logic [DEPTH_LOG2-1:0]  rd_ptr_q, rd_ptr_d;
   logic [DEPTH_LOG2:0]    count_q, count_d;
   logic [8:0]             head_q, head_d;
   logic                   rdy_q, rdy_d;
   logic                   ovr_q, ovr_d;
   logic                   last_read_q;
   logic                   full;
   logic                   pop;
   logic                   push_ok;

   assign full    = (count_q == CountMax);
   assign pop     = bus.rx_read && !last_read_q && (count_q != '0);
   // A pop in the same cycle frees a slot, so a push into a full FIFO is kept.
   assign push_ok = push && (!full || pop);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      head_d   = head_q;
      ovr_d    = ovr_q | (push & full & ~pop);

      if (pop) begin
         rd_ptr_d = rd_ptr_q + PtrOne;
      end
      if (push_ok) begin
         wr_ptr_d = wr_ptr_q + PtrOne;
      end

      case ({push_ok, pop})
         2'b10:   count_d = count_q + CountOne;
         2'b01:   count_d = count_q - CountOne;
         default: count_d = count_q;
      endcase

      // Head register tracks the next head entry; it holds its last value
      // once the FIFO drains. The new head bypasses memory when it is the
      // entry being written this cycle.
      if (count_d != '0) begin
         if (push_ok && (wr_ptr_q == rd_ptr_d)) begin
            head_d = push_entry;
         end else begin
            head_d = mem_q[rd_ptr_d];
         end
      end

      // One-clk low gap after every pop lets an edge-detecting consumer see
      // each queued byte as a fresh rx_rdy rise.
      rdy_d = !pop && (count_d != '0);
   end

   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem_q[wr_ptr_q] <= push_entry;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         head_q      <= 9'd0;
         rdy_q       <= 1'b0;
         ovr_q       <= 1'b0;
         last_read_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         head_q      <= head_d;
         rdy_q       <= rdy_d;
         ovr_q       <= ovr_d;
         last_read_q <= bus.rx_read;
      end
   end

   assign bus.rx_rdy   = rdy_q;
   assign bus.rx_data  = head_q[7:0];
   assign bus.rx_err   = head_q[8];
   assign bus.rx_count = count_q;
   assign bus.rx_ovr   = ovr_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo
//  Directed bench for uart_rx_fifo (DEPTH_LOG2=2, STOP_CHK=1). mclkx16 pulses
//  every 4 clks, so one bit is 64 clks. Expected entries go into a
//  scoreboard queue as frames are sent and are compared as they are read.
module tb_uart_rx_fifo;

   localparam int unsigned DepthLog2 = 2;
   localparam int          BitClks   = 64;

   logic       clk;
   logic       rst;
   logic       mclkx16;
   logic       rx;
   logic [1:0] mcnt;

   int n_cmp;
   int n_err;

   logic [8:0] sb_q[$];

   uart_rx_fifo_if #(.DEPTH_LOG2(DepthLog2)) bus ();

   uart_rx_fifo #(
      .DEPTH_LOG2 (DepthLog2),
      .STOP_CHK   (1'b1)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .mclkx16 (mclkx16),
      .rx      (rx),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      mcnt    = 2'd0;
      mclkx16 = 1'b0;
   end

   always @(negedge clk) begin
      mcnt    = mcnt + 2'd1;
      mclkx16 = (mcnt == 2'd0);
   end

   initial begin
      #20000000;
      $display("FAIL watchdog: simulation did not finish (got timeout, required completion)");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic idle_clks(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop_bit);
      rx = 1'b0;
      idle_clks(BitClks);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         idle_clks(BitClks);
      end
      rx = stop_bit;
      idle_clks(BitClks);
      rx = 1'b1;
   endtask

   task automatic wait_rdy(input string tag);
      int n;
      n = 0;
      while (bus.rx_rdy !== 1'b1 && n < 800) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_rdy"}, 32'(bus.rx_rdy), 32'd1);
   endtask

   task automatic read_one(input string tag);
      logic [8:0] exp;
      wait_rdy(tag);
      if (sb_q.size() == 0) begin
         check({tag, "_sb_nonempty"}, 32'(sb_q.size()), 32'd1);
      end else begin
         exp = sb_q.pop_front();
         check({tag, "_data"}, 32'(bus.rx_data), 32'(exp[7:0]));
         check({tag, "_err"}, 32'(bus.rx_err), 32'(exp[8]));
      end
      bus.rx_read = 1'b1;
      @(negedge clk);
      check({tag, "_rdy_gap"}, 32'(bus.rx_rdy), 32'd0);
      bus.rx_read = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      int         lat;
      logic [7:0] b;

      n_cmp       = 0;
      n_err       = 0;
      rst         = 1'b1;
      rx          = 1'b1;
      bus.rx_read = 1'b0;
      idle_clks(5);

      // Reset state
      check("rst_rdy",   32'(bus.rx_rdy),   32'd0);
      check("rst_data",  32'(bus.rx_data),  32'd0);
      check("rst_err",   32'(bus.rx_err),   32'd0);
      check("rst_count", 32'(bus.rx_count), 32'd0);
      check("rst_ovr",   32'(bus.rx_ovr),   32'd0);
      rst = 1'b0;
      idle_clks(BitClks);

      // 1: single byte, latency ~9.5 bit-times from the start edge
      sb_q.push_back({1'b0, 8'h41});
      lat = 0;
      fork
         send_byte(8'h41, 1'b1);
         begin
            while (bus.rx_rdy !== 1'b1 && lat < 800) begin
               @(negedge clk);
               lat++;
            end
         end
      join
      check("t1_latency", 32'(lat >= 596 && lat <= 620), 32'd1);
      check("t1_count", 32'(bus.rx_count), 32'd1);
      read_one("t1");
      check("t1_count_after", 32'(bus.rx_count), 32'd0);

      // 2: three back-to-back bytes, held rx_read pops exactly once
      send_byte(8'h55, 1'b1);
      send_byte(8'hAA, 1'b1);
      send_byte(8'h0D, 1'b1);
      sb_q.push_back({1'b0, 8'h55});
      sb_q.push_back({1'b0, 8'hAA});
      sb_q.push_back({1'b0, 8'h0D});
      check("t2_count3", 32'(bus.rx_count), 32'd3);
      check("t2_head55", 32'(bus.rx_data), 32'(sb_q[0][7:0]));
      void'(sb_q.pop_front());
      bus.rx_read = 1'b1;
      @(negedge clk);
      check("t2_rdy_gap", 32'(bus.rx_rdy), 32'd0);
      check("t2_count2", 32'(bus.rx_count), 32'd2);
      @(negedge clk);
      check("t2_rdy_back", 32'(bus.rx_rdy), 32'd1);
      idle_clks(8);
      check("t2_held_once", 32'(bus.rx_count), 32'd2);
      check("t2_headAA", 32'(bus.rx_data), 32'h0AA);
      bus.rx_read = 1'b0;
      @(negedge clk);
      read_one("t2_b");
      read_one("t2_c");

      // 3: overrun with five bytes into a four-entry FIFO
      send_byte(8'h11, 1'b1);
      send_byte(8'h22, 1'b1);
      send_byte(8'h33, 1'b1);
      send_byte(8'h44, 1'b1);
      send_byte(8'h5E, 1'b1);
      sb_q.push_back({1'b0, 8'h11});
      sb_q.push_back({1'b0, 8'h22});
      sb_q.push_back({1'b0, 8'h33});
      sb_q.push_back({1'b0, 8'h44});
      check("t3_count4", 32'(bus.rx_count), 32'd4);
      check("t3_ovr", 32'(bus.rx_ovr), 32'd1);
      for (int i = 0; i < 4; i++) begin
         read_one($sformatf("t3_rd%0d", i));
      end
      check("t3_rdy_empty", 32'(bus.rx_rdy), 32'd0);
      check("t3_ovr_sticky", 32'(bus.rx_ovr), 32'd1);
      // Pop on empty is ignored
      bus.rx_read = 1'b1;
      idle_clks(2);
      bus.rx_read = 1'b0;
      idle_clks(2);
      check("t3_empty_pop_data", 32'(bus.rx_data), 32'h044);
      check("t3_empty_pop_count", 32'(bus.rx_count), 32'd0);

      // 4: 5-tick low glitch is rejected, receiver still works afterwards
      rx = 1'b0;
      idle_clks(20);
      rx = 1'b1;
      idle_clks(4 * BitClks);
      check("t4_no_push_count", 32'(bus.rx_count), 32'd0);
      check("t4_no_push_rdy", 32'(bus.rx_rdy), 32'd0);
      send_byte(8'h5A, 1'b1);
      sb_q.push_back({1'b0, 8'h5A});
      read_one("t4_after");

      // 5: framing error followed by a break, then a clean frame
      send_byte(8'h31, 1'b0);
      rx = 1'b0;
      idle_clks(3 * BitClks);
      sb_q.push_back({1'b1, 8'h31});
      check("t5_break_count", 32'(bus.rx_count), 32'd1);
      rx = 1'b1;
      idle_clks(BitClks);
      check("t5_idle_count", 32'(bus.rx_count), 32'd1);
      send_byte(8'h32, 1'b1);
      sb_q.push_back({1'b0, 8'h32});
      check("t5_count2", 32'(bus.rx_count), 32'd2);
      read_one("t5_err");
      read_one("t5_ok");

      // 6: reset during data bit 4 with two bytes queued
      send_byte(8'hA1, 1'b1);
      send_byte(8'hB2, 1'b1);
      check("t6_count2", 32'(bus.rx_count), 32'd2);
      b  = 8'hF3;  // bits 4..7 high so the tail of the frame looks idle
      rx = 1'b0;
      idle_clks(BitClks);
      for (int i = 0; i < 4; i++) begin
         rx = b[i];
         idle_clks(BitClks);
      end
      rx = b[4];
      idle_clks(BitClks / 2);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      sb_q.delete();
      check("t6_rst_count", 32'(bus.rx_count), 32'd0);
      check("t6_rst_rdy", 32'(bus.rx_rdy), 32'd0);
      check("t6_rst_ovr", 32'(bus.rx_ovr), 32'd0);
      check("t6_rst_data", 32'(bus.rx_data), 32'd0);
      idle_clks(BitClks / 2 - 1);
      for (int i = 5; i < 8; i++) begin
         rx = b[i];
         idle_clks(BitClks);
      end
      rx = 1'b1;
      idle_clks(2 * BitClks);
      check("t6_tail_ignored", 32'(bus.rx_count), 32'd0);
      send_byte(8'h7E, 1'b1);
      sb_q.push_back({1'b0, 8'h7E});
      check("t6_count1", 32'(bus.rx_count), 32'd1);
      read_one("t6_next");
      check("t6_final_count", 32'(bus.rx_count), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
